// File: rtl/dff.sv
// Purpose : single WIDTH-bit storage register with synchronous active-low reset,
//           synchronous preset and a load enable.
// Latency : one rising clk edge from the sampled inputs to q. No backpressure: the
//           register accepts new data on every enabled edge.
//
// Ports
//   clk  - single clock; all state changes on its rising edge only
//   rst  - synchronous reset, active-low; loads RESET_VALUE (highest priority)
//   set  - synchronous preset, active-high; loads SET_VALUE
//   en   - load enable, active-high; captures d
//   d    - data to capture
//   q    - registered output, driven straight from the storage register
//
// Priority at each edge: rst low > set high > en high > hold.
module dff #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Reset is tested first, so an unknown value on set or en cannot leak into
    // the reset load. The whole word is written at once; there are no per-bit enables.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_q <= RESET_VALUE;
        end else if (set) begin
            r_q <= SET_VALUE;
        end else if (en) begin
            r_q <= d;
        end
    end

    // q comes only from the flop, so there is no combinational path from any input.
    assign q = r_q;

endmodule

// File: tb/tb_dff.sv
module tb_dff;

    logic       clk;
    logic       rst;
    logic       set;
    logic       en;
    logic [7:0] d;
    logic [7:0] q;

    int n_checks = 0;
    int n_errors = 0;

    dff #(.WIDTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .set (set),
        .en  (en),
        .d   (d),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: q=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge sample, then look 1 unit later.
    task automatic apply(input logic a_rst, input logic a_set, input logic a_en,
                         input logic [7:0] a_d);
        @(negedge clk);
        rst = a_rst;
        set = a_set;
        en  = a_en;
        d   = a_d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set = 1'b0;
        en  = 1'b0;
        d   = 8'h00;

        // Reset load
        apply(1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_state", q, 8'h00);

        // Set beats enable
        apply(1'b1, 1'b1, 1'b1, 8'h01);
        check("set_over_en", q, 8'hFF);

        // Enabled loads
        apply(1'b1, 1'b0, 1'b1, 8'h00);
        check("load_00_a", q, 8'h00);
        apply(1'b1, 1'b0, 1'b1, 8'h00);
        check("load_00_b", q, 8'h00);
        apply(1'b1, 1'b0, 1'b1, 8'h01);
        check("load_01", q, 8'h01);

        // Set without enable
        apply(1'b1, 1'b1, 1'b0, 8'h01);
        check("set_no_en", q, 8'hFF);

        // Reset beats enable
        apply(1'b1, 1'b0, 1'b1, 8'h5A);
        check("load_5a", q, 8'h5A);
        apply(1'b0, 1'b0, 1'b1, 8'h01);
        check("rst_over_en", q, 8'h00);

        // Reset beats set
        apply(1'b1, 1'b0, 1'b1, 8'h5A);
        apply(1'b0, 1'b1, 1'b1, 8'h01);
        check("rst_over_set", q, 8'h00);

        // Release of reset applies the load rule on that same edge
        apply(1'b1, 1'b0, 1'b1, 8'hC3);
        check("rst_release_load", q, 8'hC3);

        // Hold for three edges with d changing underneath
        apply(1'b1, 1'b0, 1'b1, 8'hA5);
        check("load_a5", q, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, 8'h3C);
            check($sformatf("hold_%0d", i), q, 8'hA5);
        end

        // Toggle inputs between edges: q must not move
        rst = 1'b0;
        set = 1'b1;
        d   = 8'hFF;
        #1;
        check("mid_rst_set", q, 8'hA5);
        en = 1'b1;
        d  = 8'h11;
        #1;
        check("mid_en_d", q, 8'hA5);
        rst = 1'b1;
        set = 1'b0;
        #1;
        check("mid_release", q, 8'hA5);
        apply(1'b1, 1'b0, 1'b0, 8'h77);
        check("after_toggle_edge", q, 8'hA5);

        // Unknown set/en while in reset must still give a clean reset load
        apply(1'b0, 1'bx, 1'bx, 8'h99);
        check("rst_with_x", q, 8'h00);

        // Pattern with mixed bits, then set over it
        apply(1'b1, 1'b0, 1'b1, 8'h96);
        check("load_96", q, 8'h96);
        apply(1'b1, 1'b1, 1'b0, 8'h00);
        check("set_over_96", q, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
